// File: rtl/cpu_defs_pkg.sv
// Shared CPU bus definitions: sram-like bridge state encoding and transfer size codes.
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/wen_to_size_off.sv
// Maps byte write enables to an sram-like transfer size and low address offset.
// Purely combinational, no flow control.
module wen_to_size_off
  import cpu_defs::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] off
);

  always_comb begin
    size = SIZE_WORD;
    off  = 2'd0;
    case (wen)
      4'b0001: begin size = SIZE_BYTE; off = 2'd0; end
      4'b0010: begin size = SIZE_BYTE; off = 2'd1; end
      4'b0100: begin size = SIZE_BYTE; off = 2'd2; end
      4'b1000: begin size = SIZE_BYTE; off = 2'd3; end
      4'b0011: begin size = SIZE_HALF; off = 2'd0; end
      4'b1100: begin size = SIZE_HALF; off = 2'd2; end
      // Full word and irregular masks fall back to a word transfer.
      default: begin size = SIZE_WORD; off = 2'd0; end
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Single-cycle data-SRAM port to sram-like req/addr_ok/data_ok bridge, one transfer outstanding.
// Min 2 edges (zero-wait slave); pipeline stalled until data_ok, load data held in DONE while longest_stall.
module data_sram_like_bridge
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  bridge_state_t state_q, state_d;
  logic [31:0]   rdata_r;
  logic          discard_r;
  logic [1:0]    st_size, st_off;
  logic          start, discard, resp_done, is_store;
  logic          unused_addr_bits;

  wen_to_size_off u_wen_to_size_off (
    .wen  (data_sram_wen),
    .size (st_size),
    .off  (st_off)
  );

  assign unused_addr_bits = ^data_sram_addr[1:0];
  assign is_store  = |data_sram_wen;
  assign start     = data_sram_en & ~flush;
  // A flush arriving in the same cycle as data_ok must still drop the response.
  assign discard   = discard_r | flush;
  assign resp_done = data_data_ok &
                     (((state_q == ADDR) & data_addr_ok) | (state_q == DATA));
  assign data_sram_rdata = rdata_r;

  always_comb begin
    state_d  = state_q;
    data_req = 1'b0;
    d_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        d_stall = start;
        if (start) state_d = ADDR;
      end
      ADDR: begin
        data_req = 1'b1;
        d_stall  = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) state_d = discard ? IDLE : DONE;
          else              state_d = DATA;
        end
      end
      DATA: begin
        d_stall = 1'b1;
        if (data_data_ok) state_d = discard ? IDLE : DONE;
      end
      DONE: begin
        if (!longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_wr    <= 1'b0;
      data_size  <= SIZE_BYTE;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      rdata_r    <= RESET_RDATA;
      discard_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        data_wr    <= is_store;
        data_size  <= is_store ? st_size : SIZE_WORD;
        data_addr  <= {data_sram_addr[31:2], (is_store ? st_off : 2'b00)};
        data_wdata <= data_sram_wdata;
        discard_r  <= 1'b0;
      end
      if (((state_q == ADDR) || (state_q == DATA)) && flush) discard_r <= 1'b1;
      if (resp_done) begin
        discard_r <= 1'b0;
        if (!discard && !data_wr) rdata_r <= data_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Scoreboard bench for data_sram_like_bridge: expected requests/load data queued at drive time.
module tb_data_sram_like_bridge;
  import cpu_defs::*;

  localparam logic [31:0] RST_RD = 32'hCAFE_0000;

  logic        clk, rst;
  logic        data_sram_en, flush, longest_stall, d_stall;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int checks = 0;
  int errors = 0;

  data_sram_like_bridge #(.RESET_RDATA(RST_RD)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .flush           (flush),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One memory instruction against a slave that accepts the address after aw request
  // cycles and returns data dw cycles after that; hold = DONE cycles under longest_stall.
  task automatic run_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input int aw, input int dw, input logic [31:0] resp,
                            input bit flush_data, input int hold,
                            input logic [1:0] exp_size, input logic [31:0] exp_addr);
    req_t        exp_r;
    int          cyc, req_cnt, stall_cnt, ok_at;
    bit          got;
    logic [31:0] prev_rd, exp_rd;
    cyc = 0; req_cnt = 0; stall_cnt = 0; ok_at = -1; got = 0;
    exp_r = '0;
    req_q.push_back(req_t'{wr: (wen != 4'b0), size: exp_size, addr: exp_addr, wdata: wdata});
    if (wen == 4'b0 && !flush_data) rd_q.push_back(resp);
    prev_rd = data_sram_rdata;
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    longest_stall = (hold > 0);
    while (cyc < 100) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      #1;
      if (!d_stall) break;
      stall_cnt++;
      if (data_req) begin
        if (!got) begin
          got = 1'b1;
          exp_r = req_q.pop_front();
        end
        check_val("req_wr", 32'(data_wr), 32'(exp_r.wr));
        check_val("req_size", 32'(data_size), 32'(exp_r.size));
        check_val("req_addr", data_addr, exp_r.addr);
        check_val("req_wdata", data_wdata, exp_r.wdata);
        if (req_cnt == aw) begin data_addr_ok = 1'b1; ok_at = cyc; end
        req_cnt++;
      end
      if (ok_at >= 0 && cyc == ok_at + dw) begin data_data_ok = 1'b1; data_rdata = resp; end
      if (flush_data && ok_at >= 0 && cyc > ok_at) begin flush = 1'b1; data_sram_en = 1'b0; end
      @(negedge clk);
      cyc++;
    end
    check_val("no_timeout", 32'(cyc < 100), 32'd1);
    check_val("stall_cycles", 32'(stall_cnt), 32'(2 + aw + dw));
    check_val("req_cycles", 32'(req_cnt), 32'(aw + 1));
    if (flush_data) begin
      flush = 1'b0;
      check_val("flush_state", 32'(dut.state_q), 32'(IDLE));
      check_val("flush_rdata", data_sram_rdata, prev_rd);
    end else begin
      exp_rd = (wen == 4'b0) ? rd_q.pop_front() : prev_rd;
      check_val("done_state", 32'(dut.state_q), 32'(DONE));
      check_val("done_rdata", data_sram_rdata, exp_rd);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check_val("hold_state", 32'(dut.state_q), 32'(DONE));
        check_val("hold_req", 32'(data_req), 32'd0);
        check_val("hold_rdata", data_sram_rdata, exp_rd);
      end
      longest_stall = 1'b0;
      @(negedge clk);
      data_sram_en = 1'b0;
      #1;
      check_val("release_state", 32'(dut.state_q), 32'(IDLE));
      check_val("release_rdata", data_sram_rdata, exp_rd);
    end
    data_sram_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0; flush = 1'b0; longest_stall = 1'b0;
    data_rdata = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_req", 32'(data_req), 32'd0);
    check_val("rst_wr", 32'(data_wr), 32'd0);
    check_val("rst_size", 32'(data_size), 32'd0);
    check_val("rst_addr", data_addr, 32'h0);
    check_val("rst_wdata", data_wdata, 32'h0);
    check_val("rst_rdata", data_sram_rdata, RST_RD);
    check_val("rst_stall", 32'(d_stall), 32'd0);
    rst = 1'b0;

    // Zero-wait word load, then stores with waits, then a few mapping corners.
    run_access(4'b0000, 32'hBFC0_1004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, SIZE_WORD, 32'hBFC0_1004);
    run_access(4'b0100, 32'h8000_0010, 32'h00AB_0000, 3, 2, 32'h5555_5555, 1'b0, 0, SIZE_BYTE, 32'h8000_0012);
    run_access(4'b1100, 32'h1FAF_F000, 32'hBEEF_0000, 1, 1, 32'h0, 1'b0, 0, SIZE_HALF, 32'h1FAF_F002);
    run_access(4'b0001, 32'h0000_0103, 32'h0000_0077, 0, 1, 32'h0, 1'b0, 0, SIZE_BYTE, 32'h0000_0100);
    run_access(4'b1000, 32'h0000_0200, 32'h9900_0000, 2, 0, 32'h0, 1'b0, 0, SIZE_BYTE, 32'h0000_0203);
    run_access(4'b0011, 32'h0000_0302, 32'h0000_1234, 0, 0, 32'h0, 1'b0, 0, SIZE_HALF, 32'h0000_0300);
    run_access(4'b0101, 32'h0000_0401, 32'h0102_0304, 1, 0, 32'h0, 1'b0, 0, SIZE_WORD, 32'h0000_0400);
    run_access(4'b0000, 32'h0000_0007, 32'h0, 1, 2, 32'hA5A5_5A5A, 1'b0, 0, SIZE_WORD, 32'h0000_0004);

    // Load completing under a global stall for 5 cycles.
    run_access(4'b0000, 32'h0000_1000, 32'h0, 0, 1, 32'h1234_5678, 1'b0, 5, SIZE_WORD, 32'h0000_1000);

    // Preload, then a load flushed while in DATA must leave the held data alone.
    run_access(4'b0000, 32'h0000_2000, 32'h0, 0, 0, 32'h1111_1111, 1'b0, 0, SIZE_WORD, 32'h0000_2000);
    run_access(4'b0000, 32'h0000_2004, 32'h0, 1, 2, 32'h2222_2222, 1'b1, 0, SIZE_WORD, 32'h0000_2004);
    check_val("flush_keep", data_sram_rdata, 32'h1111_1111);

    // Flush in IDLE: no request, no stall.
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'b0; data_sram_addr = 32'h0000_3000; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("idle_flush_stall", 32'(d_stall), 32'd0);
      check_val("idle_flush_req", 32'(data_req), 32'd0);
      @(negedge clk);
    end
    data_sram_en = 1'b0; flush = 1'b0;

    // Async reset between edges while in ADDR, then a stray data_ok.
    data_sram_en = 1'b1; data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_4000;
    data_sram_wdata = 32'hFFFF_0000;
    @(negedge clk);
    data_sram_en = 1'b0;
    #1;
    check_val("pre_rst_req", 32'(data_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_req", 32'(data_req), 32'd0);
    check_val("arst_state", 32'(dut.state_q), 32'(IDLE));
    check_val("arst_wr", 32'(data_wr), 32'd0);
    check_val("arst_size", 32'(data_size), 32'd0);
    check_val("arst_addr", data_addr, 32'h0);
    check_val("arst_wdata", data_wdata, 32'h0);
    check_val("arst_rdata", data_sram_rdata, RST_RD);
    check_val("arst_stall", 32'(d_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h3333_3333;
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    check_val("stray_ok_state", 32'(dut.state_q), 32'(IDLE));
    check_val("stray_ok_rdata", data_sram_rdata, RST_RD);
    check_val("stray_ok_req", 32'(data_req), 32'd0);
    check_val("sb_req_empty", 32'(req_q.size()), 32'd0);
    check_val("sb_rd_empty", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
